// File: rtl/axis_hscaler_nch.sv
// Streaming horizontal scaler: two-pixel window, per-channel bilinear/nearest
// lanes, three-stage pipeline and an optional registered output relay.

module axis_hscaler_lane #(
  parameter int CW = 8,
  parameter int F  = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          mode,
  input  logic [CW-1:0] left,
  input  logic [CW-1:0] right,
  input  logic [F-1:0]  frac,
  output logic [CW-1:0] res
);
  localparam logic [F:0]      ONE  = {1'b1, {F{1'b0}}};
  localparam logic [CW+F+1:0] HALF = {{(CW+2){1'b0}}, 1'b1, {(F-1){1'b0}}};

  logic [F:0]      wl;
  logic [CW+F:0]   prod_l, prod_r;
  logic [CW-1:0]   near;
  logic [CW+F+1:0] sum;

  assign wl = ONE - {1'b0, frac};

  // multiply stage
  always_ff @(posedge clk) begin
    if (en) begin
      prod_l <= {{(F+1){1'b0}}, left} * {{CW{1'b0}}, wl};
      prod_r <= {{(F+1){1'b0}}, right} * {{(CW+1){1'b0}}, frac};
      near   <= frac[F-1] ? right : left;
    end
  end

  assign sum = {1'b0, prod_l} + {1'b0, prod_r} + HALF;

  // sum/round stage
  always_ff @(posedge clk) begin
    if (en) res <= mode ? near : CW'(sum >> F);
  end
endmodule

module axis_hscaler_nch #(
  parameter int C_CH_WIDTH  = 8,
  parameter int C_CH_NUM    = 3,
  parameter int C_SW_WIDTH  = 12,
  parameter int C_MW_WIDTH  = 12,
  parameter int C_FRAC_BITS = 8,
  parameter int C_OUT_RELAY = 1
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      fsync,
  input  logic                                      mode,
  input  logic [C_SW_WIDTH-1:0]                     s_width,
  input  logic [C_MW_WIDTH-1:0]                     m_width,
  input  logic [C_SW_WIDTH+C_FRAC_BITS-1:0]         h_step,
  input  logic                                      s_axis_tvalid,
  input  logic [C_CH_NUM*C_CH_WIDTH-1:0]            s_axis_tdata,
  input  logic                                      s_axis_tuser,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic                                      m_axis_tvalid,
  output logic [C_CH_NUM*C_CH_WIDTH-1:0]            m_axis_tdata,
  output logic                                      m_axis_tuser,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic                                      err_len
);
  localparam int PW     = C_CH_NUM * C_CH_WIDTH;
  localparam int SW     = C_SW_WIDTH;
  localparam int MW     = C_MW_WIDTH;
  localparam int F      = C_FRAC_BITS;
  localparam int STW    = SW + F;
  localparam int PSW    = STW + 1;
  localparam int STAGES = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic            mode_r;
  logic [SW-1:0]   sw_r, sw_m1, in_cnt, pos_int;
  logic [MW-1:0]   mw_r, out_cnt;
  logic [STW-1:0]  step_r;
  logic [PSW-1:0]  pos, pos_nxt;
  logic [PSW:0]    pos_sum;
  logic [SW:0]     pos_hi, win_end, in_ext;
  logic [PW-1:0]   win_a, win_b, o_data;
  logic            first_pend;

  logic en, emit, emit_a, emit_b, accept, last_out, line_done, run_rdy;
  logic [STAGES-1:0] vld_pipe, usr_pipe, lst_pipe;

  logic [C_CH_NUM-1:0][C_CH_WIDTH-1:0] left_px, right_px, s2_px;

  logic unused_tuser;
  assign unused_tuser = s_axis_tuser;

  // Whole block freezes while the output holds an unaccepted beat.
  assign en = !(m_axis_tvalid && !m_axis_tready);

  assign sw_m1     = sw_r - SW'(1);
  assign pos_hi    = pos[PSW-1:F];
  assign pos_int   = (pos_hi > {1'b0, sw_m1}) ? sw_m1 : pos_hi[SW-1:0];
  assign win_end   = {1'b0, pos_int} + (SW+1)'(2);
  assign in_ext    = {1'b0, in_cnt};
  assign line_done = (in_cnt == sw_r);
  assign last_out  = (out_cnt == mw_r - MW'(1));

  // Edge clamp fires once the line is fully in and the phase sits on the last pixel.
  assign emit_a = (in_ext == win_end);
  assign emit_b = line_done && (pos_int == sw_m1);
  assign emit   = (state_q == RUN) && (emit_a || emit_b) && en && !fsync;

  assign run_rdy       = (state_q == RUN) && (in_ext < win_end) && !line_done;
  assign s_axis_tready = en && !fsync && (run_rdy || (state_q == DRAIN && !line_done));
  assign accept        = s_axis_tready && s_axis_tvalid;

  // Saturate so a huge step can never wrap the phase back into the line.
  assign pos_sum = {1'b0, pos} + (PSW+1)'(step_r);
  assign pos_nxt = pos_sum[PSW] ? '1 : pos_sum[PSW-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fsync) begin
      state_d = (s_width == '0 || m_width == '0) ? IDLE : RUN;
    end else begin
      case (state_q)
        RUN:     if (emit && last_out && !line_done) state_d = DRAIN;
        DRAIN:   if (accept && in_cnt == sw_m1)      state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_r     <= 1'b0;
      sw_r       <= '0;
      mw_r       <= '0;
      step_r     <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      pos        <= '0;
      win_a      <= '0;
      win_b      <= '0;
      first_pend <= 1'b0;
      err_len    <= 1'b0;
    end else if (fsync) begin
      mode_r     <= mode;
      sw_r       <= s_width;
      mw_r       <= m_width;
      step_r     <= h_step;
      in_cnt     <= '0;
      out_cnt    <= '0;
      pos        <= '0;
      win_a      <= '0;
      win_b      <= '0;
      first_pend <= 1'b1;
      err_len    <= 1'b0;
    end else begin
      if (accept) begin
        win_a  <= win_b;
        win_b  <= s_axis_tdata;
        in_cnt <= in_cnt + SW'(1);
        if (s_axis_tlast != (in_cnt == sw_m1)) err_len <= 1'b1;
      end
      if (emit) begin
        first_pend <= 1'b0;
        pos        <= pos_nxt;
        out_cnt    <= out_cnt + MW'(1);
        if (last_out) begin
          out_cnt <= '0;
          pos     <= '0;
          if (line_done) begin
            in_cnt <= '0;
            win_a  <= '0;
            win_b  <= '0;
          end
        end
      end
      if (accept && state_q == DRAIN && in_cnt == sw_m1) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        pos     <= '0;
        win_a   <= '0;
        win_b   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      usr_pipe <= '0;
      lst_pipe <= '0;
    end else if (fsync) begin
      vld_pipe <= '0;
      usr_pipe <= '0;
      lst_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], emit};
      usr_pipe <= {usr_pipe[STAGES-2:0], emit && first_pend};
      lst_pipe <= {lst_pipe[STAGES-2:0], emit && last_out};
    end
  end

  assign left_px  = emit_b ? win_b : win_a;
  assign right_px = win_b;

  for (genvar g = 0; g < C_CH_NUM; g++) begin : g_lane
    axis_hscaler_lane #(.CW(C_CH_WIDTH), .F(F)) u_lane (
      .clk   (clk),
      .en    (en),
      .mode  (mode_r),
      .left  (left_px[g]),
      .right (right_px[g]),
      .frac  (pos[F-1:0]),
      .res   (s2_px[g])
    );
  end

  always_ff @(posedge clk) begin
    if (en) o_data <= s2_px;
  end

  if (C_OUT_RELAY != 0) begin : g_relay
    logic          r_vld, r_usr, r_lst;
    logic [PW-1:0] r_data;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_vld <= 1'b0;
        r_usr <= 1'b0;
        r_lst <= 1'b0;
      end else if (fsync) begin
        r_vld <= 1'b0;
        r_usr <= 1'b0;
        r_lst <= 1'b0;
      end else if (en) begin
        r_vld <= vld_pipe[STAGES-1];
        r_usr <= usr_pipe[STAGES-1];
        r_lst <= lst_pipe[STAGES-1];
      end
    end

    always_ff @(posedge clk) begin
      if (en) r_data <= o_data;
    end

    assign m_axis_tvalid = r_vld;
    assign m_axis_tuser  = r_usr;
    assign m_axis_tlast  = r_lst;
    assign m_axis_tdata  = r_data;
  end else begin : g_pass
    assign m_axis_tvalid = vld_pipe[STAGES-1];
    assign m_axis_tuser  = usr_pipe[STAGES-1];
    assign m_axis_tlast  = lst_pipe[STAGES-1];
    assign m_axis_tdata  = o_data;
  end
endmodule

// File: tb/tb_axis_hscaler_nch.sv
// Directed bench for axis_hscaler_nch: up/down scale, drain, nearest,
// random backpressure, mid-line fsync and line-length error.

module tb_axis_hscaler_nch;
  logic        clk, resetn, fsync, mode;
  logic [11:0] s_width, m_width;
  logic [19:0] h_step;
  logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
  logic [23:0] s_axis_tdata, m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
  logic        err_len;

  axis_hscaler_nch dut (
    .clk(clk), .resetn(resetn), .fsync(fsync), .mode(mode),
    .s_width(s_width), .m_width(m_width), .h_step(h_step),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .err_len(err_len)
  );

  int n_cmp = 0, n_err = 0;
  bit rep, rnd_ready, chk_stable, stall_prev;
  logic [25:0] outq[$];
  logic [25:0] held;
  logic [23:0] src_q[$], exp_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output capture plus hold-stability check while stalled.
  always @(negedge clk) begin
    if (resetn && chk_stable && stall_prev) begin
      chk("stall_valid", m_axis_tvalid, 1);
      chk("stall_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
    end
    stall_prev = m_axis_tvalid && !m_axis_tready;
    held = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
  end

  task automatic frame(input logic md, input int sw, input int mw, input int step);
    mode = md; s_width = 12'(sw); m_width = 12'(mw); h_step = 20'(step);
    fsync = 1'b1;
    @(negedge clk);
    chk("fsync_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    fsync = 1'b0;
  endtask

  task automatic send_line(input int last_idx);
    int i, guard;
    logic hs;
    i = 0; guard = 0;
    while (i < src_q.size()) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = rep ? {3{src_q[i][7:0]}} : src_q[i];
      s_axis_tlast  = (i == last_idx);
      @(negedge clk); hs = s_axis_tready;
      @(posedge clk); #1;
      if (hs) begin
        i++; guard = 0;
      end else if (++guard > 500) begin
        chk("in_timeout", i, src_q.size());
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int c;
    c = 0;
    while (outq.size() < n && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    repeat (12) begin @(posedge clk); #1; end
    chk("out_count", outq.size(), n);
  endtask

  task automatic check_line(input int base, input bit first_user);
    logic [23:0] e;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k >= outq.size()) begin
        chk("missing_out", outq.size(), base + k + 1);
        break;
      end
      e = rep ? {3{exp_q[k][7:0]}} : exp_q[k];
      chk("tdata", outq[base+k][23:0], e);
      chk("tuser", outq[base+k][25], (first_user && k == 0));
      chk("tlast", outq[base+k][24], (k == exp_q.size() - 1));
    end
  endtask

  task automatic ramp(input int start, input int step, input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(24'(start + i * step));
  endtask

  initial begin
    resetn = 0; fsync = 0; mode = 0; s_width = 0; m_width = 0; h_step = 0;
    s_axis_tvalid = 1; s_axis_tdata = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    rep = 1; rnd_ready = 0; chk_stable = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_err_len", err_len, 0);
    @(posedge clk); #1; resetn = 1;
    @(negedge clk);
    chk("idle_tready", s_axis_tready, 0);
    @(posedge clk); #1; s_axis_tvalid = 0;

    // upscale x2, two lines
    frame(0, 4, 8, 'h080);
    outq.delete();
    src_q = '{0, 100, 200, 40};
    exp_q = '{0, 50, 100, 150, 200, 120, 40, 40};
    send_line(3); send_line(3);
    wait_outs(16);
    check_line(0, 1); check_line(8, 0);
    chk("up_err_len", err_len, 0);

    // downscale /2, second line starts clean
    frame(0, 8, 4, 'h200);
    outq.delete();
    ramp(10, 10, 8); send_line(7);
    ramp(110, 10, 8); send_line(7);
    wait_outs(8);
    exp_q = '{10, 30, 50, 70};     check_line(0, 1);
    exp_q = '{110, 130, 150, 170}; check_line(4, 0);

    // short output line forces a drain of the remaining input
    frame(0, 8, 2, 'h100);
    outq.delete();
    ramp(1, 1, 8);  send_line(7);
    ramp(11, 1, 8); send_line(7);
    wait_outs(4);
    exp_q = '{1, 2};   check_line(0, 1);
    exp_q = '{11, 12}; check_line(2, 0);

    // nearest, three independent channels
    rep = 0;
    frame(1, 2, 3, 'h0C0);
    outq.delete();
    src_q = '{24'h102030, 24'h405060};
    send_line(1);
    wait_outs(3);
    exp_q = '{24'h102030, 24'h405060, 24'h405060};
    check_line(0, 1);
    rep = 1;

    // random backpressure
    frame(0, 4, 8, 'h080);
    outq.delete();
    rnd_ready = 1; chk_stable = 1;
    src_q = '{0, 100, 200, 40};
    send_line(3); send_line(3);
    wait_outs(16);
    chk_stable = 0; rnd_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    exp_q = '{0, 50, 100, 150, 200, 120, 40, 40};
    check_line(0, 1); check_line(8, 0);

    // fsync while outputs 2/3 are in flight
    frame(0, 4, 8, 'h080);
    outq.delete();
    src_q = '{0, 100}; send_line(-1);
    wait_outs(2);
    chk("mid_out0", outq[0][23:0], 24'h000000);
    chk("mid_out1", outq[1][23:0], 24'h323232);
    src_q = '{200}; send_line(-1);
    @(posedge clk); #1;
    frame(0, 4, 8, 'h080);
    src_q = '{0, 100, 200, 40};
    send_line(3);
    wait_outs(10);
    exp_q = '{0, 50, 100, 150, 200, 120, 40, 40};
    check_line(2, 1);

    // early tlast flags err_len without disturbing output
    frame(0, 4, 8, 'h080);
    outq.delete();
    send_line(2);
    wait_outs(8);
    check_line(0, 1);
    chk("err_set", err_len, 1);
    frame(0, 4, 8, 'h080);
    chk("err_clr", err_len, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
